serial_source_port: RTL and testbench
=====================================

// Module: serial_source_port
//
// PURPOSE
//   Upstream feeder for the SAP-II serial input port (input port 2).
//   - Buffers parallel bytes from an external device in a small FIFO.
//   - Serializes each byte LSB-first on serial_out, framed by ready.
//   - The downstream port shifts while ready is high and drives WBUS.
//
// PARAMETERS
//   DATA_WIDTH  8  bits per frame; ready stays high DATA_WIDTH cycles (DATA_WIDTH+1 with parity)
//   FIFO_DEPTH  4  byte buffer entries; power of 2, >= 2
//   GAP_CYCLES  2  idle cycles with ready=0 between frames; >= 1
//
// PORTS
//   CLK         in   1           clock; all state updates on posedge
//   nCLR        in   1           reset, asynchronous, active-low (0: clear)
//   data_in     in   DATA_WIDTH  byte from external device
//   wr_en       in   1           push data_in into FIFO this edge
//   full        out  1           FIFO holds FIFO_DEPTH entries (combinational from count)
//   empty       out  1           FIFO holds 0 entries (combinational from count)
//   overflow    out  1           sticky: a write was attempted while full
//   ready       out  1           frame-valid strobe to downstream port (registered)
//   serial_out  out  1           serial data bit (registered)
//   done        out  1           one-cycle pulse after the last bit of a frame
//
// BEHAVIOUR
//   Reset (nCLR=0, asynchronous, independent of CLK):
//     - FIFO count and pointers = 0; state = IDLE.
//     - ready=0, serial_out=0, done=0, overflow=0.
//     - Asserting reset mid-frame aborts the frame immediately; the byte is lost.
//   FIFO:
//     - Write when wr_en && !full: data_in goes to the tail, count+1.
//     - wr_en && full: write is dropped and overflow is set. This holds even
//       if a pop happens on the same edge, because full is the pre-edge value.
//     - A write and a pop on the same edge when not full: count is unchanged.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - A byte written into an empty FIFO at edge t is popped at edge t+1
//       if the FSM is in IDLE.
//   FSM states: IDLE, SHIFT, GAP (plus PARITY when PARITY_EN is defined).
//     IDLE, !empty:
//       - pop head into shreg; bit_cnt=0.
//       - ready<=1, serial_out<=head[0]; go to SHIFT.
//     IDLE, empty: hold; ready=0, serial_out=0.
//     SHIFT, bit_cnt < DATA_WIDTH-1:
//       - bit_cnt+1; serial_out<=shreg[bit_cnt+1]; ready stays 1.
//     SHIFT, bit_cnt == DATA_WIDTH-1:
//       - ready<=0, serial_out<=0, done<=1, gap_cnt=0; go to GAP.
//     GAP:
//       - done<=0; gap_cnt+1.
//       - When gap_cnt == GAP_CYCLES-1, go to IDLE.
//   Timing contract:
//     - ready is high for exactly DATA_WIDTH consecutive cycles.
//     - In the k-th cycle of that window (k=0..DATA_WIDTH-1), serial_out = byte[k].
//     - ready and serial_out change on the same edge, so downstream sampling
//       at posedge sees stable values.
//     - Back-to-back frames are separated by GAP_CYCLES+1 cycles with ready=0
//       (GAP_CYCLES in GAP plus one IDLE).
//     - Writes are accepted in any state; the FSM pops only in IDLE.
//
// CONFIGURATION
//   PARITY_EN defined:
//     - After the last data bit, enter PARITY for one cycle.
//     - Drive serial_out = ^byte (even parity); ready stays 1, so the window
//       is DATA_WIDTH+1 cycles.
//     - done pulses in the cycle after PARITY.
//   PARITY_EN undefined: no PARITY state; window is DATA_WIDTH cycles.
//
// TESTING
//   T1 reset: nCLR=0 mid-frame (after 3 bits of 8'hA5)
//      -> ready=0, serial_out=0, empty=1, overflow=0 with no clock edge required.
//   T2 single frame: write 8'hB4, then idle
//      -> ready high 8 cycles; serial_out = 0,0,1,0,1,1,0,1; done pulses once.
//   T3 back-to-back: write 8'h01, 8'h80 on consecutive edges
//      -> two 8-cycle windows, 3 cycles of ready=0 between them (GAP_CYCLES=2).
//   T4 full/overflow: 5 writes with no pops (hold FSM busy)
//      -> full=1 after 4th write; 5th dropped; overflow=1 and stays 1 until nCLR.
//   T5 wrap: stream 10 bytes 8'h00..8'h09 keeping the FIFO non-full
//      -> serial reassembly equals the input order with no loss.
//   T6 PARITY_EN: write 8'h07
//      -> 9-cycle ready window; the 9th bit = 1; done follows the 9th bit.

Source files
------------

// File: rtl/serial_source_port_if.sv
// Byte-in / serial-out handshake bundle for serial_source_port.
// Latency: none (wires only).
// Backpressure: none here; full/overflow report FIFO state back to the writer.
interface serial_source_port_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  ready;
  logic                  serial_out;
  logic                  done;

  // Device side: pushes bytes, watches FIFO state and the serial stream.
  modport master (
    output data_in, wr_en,
    input  full, empty, overflow, ready, serial_out, done
  );

  // Port side: accepts bytes, produces FIFO state and the serial stream.
  modport slave (
    input  data_in, wr_en,
    output full, empty, overflow, ready, serial_out, done
  );
endinterface

// File: rtl/serial_source_port.sv
// Buffers parallel bytes in a small FIFO and serializes them LSB-first, framed by ready.
// Latency: byte written at edge t into an idle, empty port drives its first bit after edge t+1.
// Backpressure: writes while full are dropped and latch the sticky overflow flag.
// Build option: define PARITY_EN to append an even-parity bit inside each ready window.
module serial_source_port #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic                 CLK,
  input logic                 nCLR,
  serial_source_port_if.slave port
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Full/empty come straight from the count so the writer sees them this cycle.
  assign full_w  = (count == CNT_FULL);
  assign empty_w = (count == '0);
  assign head    = mem[rd_ptr];

  // Full is the pre-edge value, so a write while full is dropped even if the
  // FSM pops on the same edge.
  assign push = port.wr_en && !full_w;

  // Storage array has no reset; only pointers and count define valid contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= port.data_in;
    end
  end

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (port.wr_en && full_w) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t                state,     state_nxt;
  logic [DATA_WIDTH-1:0] shreg,     shreg_nxt;
  logic [BIT_W-1:0]      bit_cnt,   bit_cnt_nxt;
  logic [GAP_W-1:0]      gap_cnt,   gap_cnt_nxt;
  logic                  ready_q,   ready_nxt;
  logic                  sout_q,    sout_nxt;
  logic                  done_q,    done_nxt;

  // State and registered outputs; reset mid-frame discards the byte in flight.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ready_q <= 1'b0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      ready_q <= ready_nxt;
      sout_q  <= sout_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state and next-output decode; ready and serial_out always move together.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    ready_nxt   = ready_q;
    sout_nxt    = sout_q;
    done_nxt    = 1'b0;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        if (!empty_w) begin
          // Load the head byte and present bit 0 on the same edge ready rises.
          pop         = 1'b1;
          shreg_nxt   = head;
          bit_cnt_nxt = '0;
          ready_nxt   = 1'b1;
          sout_nxt    = head[0];
          state_nxt   = SHIFT;
        end else begin
          ready_nxt = 1'b0;
          sout_nxt  = 1'b0;
        end
      end

      SHIFT: begin
        if (bit_cnt != BIT_LAST) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          sout_nxt    = shreg[bit_cnt_nxt];
        end else begin
`ifdef PARITY_EN
          // One extra cycle inside the window carries even parity of the byte.
          sout_nxt  = ^shreg;
          state_nxt = PARITY;
`else
          ready_nxt   = 1'b0;
          sout_nxt    = 1'b0;
          done_nxt    = 1'b1;
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
`endif
        end
      end

`ifdef PARITY_EN
      PARITY: begin
        ready_nxt   = 1'b0;
        sout_nxt    = 1'b0;
        done_nxt    = 1'b1;
        gap_cnt_nxt = '0;
        state_nxt   = GAP;
      end
`endif

      GAP: begin
        // Quiet spacing so downstream sees ready low between frames.
        gap_cnt_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        ready_nxt = 1'b0;
        sout_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign port.full       = full_w;
  assign port.empty      = empty_w;
  assign port.overflow   = overflow_q;
  assign port.ready      = ready_q;
  assign port.serial_out = sout_q;
  assign port.done       = done_q;

endmodule

// File: tb/tb_serial_source_port.sv
// Directed bench for serial_source_port: reset, single/back-to-back frames,
// full/overflow, pointer wrap and (when PARITY_EN is defined) the parity bit.
module tb_serial_source_port;

`ifdef PARITY_EN
  localparam int WIN = 9;
`else
  localparam int WIN = 8;
`endif

  logic CLK;
  logic nCLR;

  serial_source_port_if #(.DATA_WIDTH(8)) sif ();

  serial_source_port #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .GAP_CYCLES(2)
  ) dut (
    .CLK  (CLK),
    .nCLR (nCLR),
    .port (sif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Frame monitor state, sampled on the falling edge.
  logic [31:0] rx_q[$];
  int          len_q[$];
  int          gap_q[$];
  logic [31:0] cur;
  int          wlen;
  int          low_run;
  int          done_cnt;
  int          done_ok;
  bit          have_prev;
  logic        prev_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(input logic [7:0] b);
`ifdef PARITY_EN
    return {23'b0, ^b, b};
`else
    return {24'b0, b};
`endif
  endfunction

  function automatic logic [31:0] rx_at(input int k);
    if (k < rx_q.size()) return rx_q[k];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] len_at(input int k);
    if (k < len_q.size()) return 32'(len_q[k]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gap_at(input int k);
    if (k < gap_q.size()) return 32'(gap_q[k]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    cur = '0; wlen = 0; low_run = 0; done_cnt = 0; done_ok = 0;
    have_prev = 1'b0; prev_ready = 1'b0;
  end

  always @(negedge CLK) begin
    if (sif.ready === 1'b1) begin
      if (!prev_ready && have_prev) gap_q.push_back(low_run);
      cur  = cur | (32'(sif.serial_out) << wlen);
      wlen = wlen + 1;
    end else begin
      if (prev_ready) begin
        rx_q.push_back(cur);
        len_q.push_back(wlen);
        cur       = '0;
        wlen      = 0;
        have_prev = 1'b1;
        low_run   = 0;
      end
      low_run = low_run + 1;
    end
    if (sif.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (prev_ready && sif.ready !== 1'b1) done_ok = done_ok + 1;
    end
    prev_ready = (sif.ready === 1'b1);
  end

  task automatic mon_clear();
    rx_q.delete();
    len_q.delete();
    gap_q.delete();
    cur = '0; wlen = 0; low_run = 0; done_cnt = 0; done_ok = 0;
    have_prev = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the write taken.
  task automatic wr1(input logic [7:0] d);
    sif.data_in = d;
    sif.wr_en   = 1'b1;
    @(posedge CLK); #1;
    sif.wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && sif.ready !== 1'b1; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nCLR        = 1'b0;
    sif.data_in = '0;
    sif.wr_en   = 1'b0;

    // Reset values, no clock edge needed.
    #1;
    chk("rst_ready",    32'(sif.ready),      32'd0);
    chk("rst_serial",   32'(sif.serial_out), 32'd0);
    chk("rst_done",     32'(sif.done),       32'd0);
    chk("rst_empty",    32'(sif.empty),      32'd1);
    chk("rst_full",     32'(sif.full),       32'd0);
    chk("rst_overflow", 32'(sif.overflow),   32'd0);
    #2 nCLR = 1'b1;
    @(posedge CLK); #1;
    idle(2);
    mon_clear();

    // T2: single frame of 8'hB4 -> bits 0,0,1,0,1,1,0,1.
    wr1(8'hB4);
    wait_frames(1, 40);
    idle(4);
    chk("t2_frames",  32'(rx_q.size()), 32'd1);
    chk("t2_byte",    rx_at(0),         exp_frame(8'hB4));
    chk("t2_len",     len_at(0),        32'(WIN));
    chk("t2_done",    32'(done_cnt),    32'd1);
    chk("t2_done_at", 32'(done_ok),     32'd1);
    chk("t2_empty",   32'(sif.empty),   32'd1);
    mon_clear();

    // T3: back-to-back 8'h01, 8'h80 -> 3 idle cycles between windows.
    wr1(8'h01);
    wr1(8'h80);
    wait_frames(2, 60);
    idle(4);
    chk("t3_frames", 32'(rx_q.size()), 32'd2);
    chk("t3_byte0",  rx_at(0),         exp_frame(8'h01));
    chk("t3_byte1",  rx_at(1),         exp_frame(8'h80));
    chk("t3_len0",   len_at(0),        32'(WIN));
    chk("t3_len1",   len_at(1),        32'(WIN));
    chk("t3_gap",    gap_at(0),        32'd3);
    chk("t3_done",   32'(done_cnt),    32'd2);
    mon_clear();

    // T4: keep FSM busy, then 5 writes -> full after 4th, 5th dropped.
    wr1(8'h3C);
    wait_ready(10);
    chk("t4_busy", 32'(sif.ready), 32'd1);
    wr1(8'h11);
    wr1(8'h22);
    wr1(8'h33);
    chk("t4_not_full3", 32'(sif.full), 32'd0);
    wr1(8'h44);
    chk("t4_full4",  32'(sif.full),     32'd1);
    chk("t4_ovf4",   32'(sif.overflow), 32'd0);
    wr1(8'h55);
    chk("t4_full5",  32'(sif.full),     32'd1);
    chk("t4_ovf5",   32'(sif.overflow), 32'd1);
    wait_frames(5, 150);
    idle(20);
    chk("t4_frames", 32'(rx_q.size()), 32'd5);
    chk("t4_byte0",  rx_at(0), exp_frame(8'h3C));
    chk("t4_byte1",  rx_at(1), exp_frame(8'h11));
    chk("t4_byte2",  rx_at(2), exp_frame(8'h22));
    chk("t4_byte3",  rx_at(3), exp_frame(8'h33));
    chk("t4_byte4",  rx_at(4), exp_frame(8'h44));
    chk("t4_empty",  32'(sif.empty),    32'd1);
    chk("t4_ovf_sticky", 32'(sif.overflow), 32'd1);
    mon_clear();

    // T1: reset after 3 bits of 8'hA5; outputs clear without a clock edge.
    wr1(8'hA5);
    wait_ready(10);
    chk("t1_started", 32'(sif.ready), 32'd1);
    idle(3);
    chk("t1_ovf_before", 32'(sif.overflow), 32'd1);
    #2 nCLR = 1'b0;
    #1;
    chk("t1_ready",    32'(sif.ready),      32'd0);
    chk("t1_serial",   32'(sif.serial_out), 32'd0);
    chk("t1_empty",    32'(sif.empty),      32'd1);
    chk("t1_overflow", 32'(sif.overflow),   32'd0);
    #2 nCLR = 1'b1;
    @(posedge CLK); #1;
    chk("t1_partial_len",  len_at(0), 32'd3);
    chk("t1_partial_bits", rx_at(0),  32'd5);
    mon_clear();
    idle(20);
    chk("t1_byte_lost", 32'(rx_q.size()), 32'd0);
    mon_clear();

    // T5: stream 8'h00..8'h09, writing only while not full; pointers wrap.
    begin
      int idx = 0;
      for (int c = 0; c < 300 && (idx < 10 || rx_q.size() < 10); c++) begin
        if (idx < 10 && sif.full === 1'b0) begin
          sif.data_in = 8'(idx);
          sif.wr_en   = 1'b1;
          idx++;
        end else begin
          sif.wr_en   = 1'b0;
        end
        @(posedge CLK); #1;
      end
      sif.wr_en = 1'b0;
    end
    idle(4);
    chk("t5_frames", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_byte%0d", i), rx_at(i), exp_frame(8'(i)));
    end
    chk("t5_overflow", 32'(sif.overflow), 32'd0);
    chk("t5_done",     32'(done_cnt),     32'd10);
    mon_clear();

`ifdef PARITY_EN
    // T6: 8'h07 -> 9-cycle window, 9th bit is parity 1, done right after.
    wr1(8'h07);
    wait_frames(1, 40);
    idle(4);
    chk("t6_len",     len_at(0),     32'd9);
    chk("t6_bits",    rx_at(0),      32'h107);
    chk("t6_done_at", 32'(done_ok),  32'd1);
    mon_clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
